// File: rtl/obuf_port_arbiter_pkg.sv
// Shared types and default sizes for the output-BRAM port arbiter.
package obuf_arb_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 1024;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ACC  = 2'd1,
    SEL_RD   = 2'd2,
    SEL_CLR  = 2'd3
  } grant_sel_e;

  // True when the address being issued is the final word of the sweep.
  function automatic logic sweep_last(input logic [31:0] cnt, input int depth);
    return (cnt == 32'(depth - 1));
  endfunction

endpackage

// File: rtl/obuf_port_arbiter_if.sv
// Request/grant and BRAM-port bundle between the requesters, the arbiter and the BRAM.
interface obuf_port_arbiter_if
  import obuf_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              clear_req;
  logic              clear_busy;
  logic              clear_done;
  logic              acc_req;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_gnt;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              bram_en;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic [DATA_W-1:0] bram_dout;

  modport master (
    output clear_req, acc_req, acc_addr, acc_wdata, rd_req, rd_addr, bram_dout,
    input  clear_busy, clear_done, acc_gnt, rd_gnt, rd_valid, rd_data,
           bram_en, bram_we, bram_addr, bram_din
  );

  modport slave (
    input  clear_req, acc_req, acc_addr, acc_wdata, rd_req, rd_addr, bram_dout,
    output clear_busy, clear_done, acc_gnt, rd_gnt, rd_valid, rd_data,
           bram_en, bram_we, bram_addr, bram_din
  );

endinterface

// File: rtl/obuf_port_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; the requester that lost the last contested cycle goes first.
module obuf_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic last_b_r;

  // Grant decode; a contested cycle goes to whoever did not win the previous one.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (en) begin
      if (req_a && req_b) begin
        gnt_a = last_b_r;
        gnt_b = ~last_b_r;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end else begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end
  end

  // Last-winner register, reset as if b had just won so that a wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_b_r <= 1'b1;
    end else if (en && req_a && req_b) begin
      last_b_r <= gnt_b;
    end else begin
      last_b_r <= last_b_r;
    end
  end

endmodule

// File: rtl/obuf_port_arbiter.sv
// Shares the output-BRAM port among clear sweep, accumulator writes and readout.
// Define OBUF_ARB_RR_EN for round-robin acc/rd arbitration; otherwise acc has fixed priority.
module obuf_port_arbiter
  import obuf_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input logic                clk,
  input logic                rst,
  obuf_port_arbiter_if.slave bus
);

  localparam int CNT_W = ADDR_W + 1;

  arb_state_e        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              clear_q_r;
  logic              clear_busy_r;
  logic              clear_done_r;
  logic              rd_v1_r;
  logic              rd_valid_r;
  logic              bram_en_r;
  logic              bram_we_r;
  logic [ADDR_W-1:0] bram_addr_r;
  logic [DATA_W-1:0] bram_din_r;

  logic              clear_rise_s;
  logic              arb_en_s;
  logic [CNT_W-1:0]  issue_s;
  logic              last_s;
  logic              acc_win_s;
  logic              rd_win_s;
  grant_sel_e        sel_s;

  assign clear_rise_s = bus.clear_req & ~clear_q_r;
  assign arb_en_s     = (state_r == ARB) && !bus.clear_req;

  // Address issued this sweep cycle; a fresh request during a sweep restarts at word 0.
  always_comb begin
    issue_s = cnt_r;
    if (clear_rise_s) begin
      issue_s = '0;
    end else begin
      issue_s = cnt_r;
    end
  end

  assign last_s = sweep_last(32'(issue_s), DEPTH);

`ifdef OBUF_ARB_RR_EN
  obuf_rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en_s),
    .req_a (bus.acc_req),
    .req_b (bus.rd_req),
    .gnt_a (acc_win_s),
    .gnt_b (rd_win_s)
  );
`else
  // Fixed priority: accumulator write-back beats readout.
  always_comb begin
    acc_win_s = 1'b0;
    rd_win_s  = 1'b0;
    if (arb_en_s) begin
      acc_win_s = bus.acc_req;
      rd_win_s  = bus.rd_req & ~bus.acc_req;
    end else begin
      acc_win_s = 1'b0;
      rd_win_s  = 1'b0;
    end
  end
`endif

  // Port owner for this cycle; the sweep owns the port outright.
  always_comb begin
    sel_s = SEL_NONE;
    if (state_r == CLEAR) begin
      sel_s = SEL_CLR;
    end else if (acc_win_s) begin
      sel_s = SEL_ACC;
    end else if (rd_win_s) begin
      sel_s = SEL_RD;
    end else begin
      sel_s = SEL_NONE;
    end
  end

  // Sequencer: idle arbitration versus zero-fill sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ARB;
      cnt_r        <= '0;
      clear_q_r    <= 1'b0;
      clear_busy_r <= 1'b0;
      clear_done_r <= 1'b0;
    end else begin
      clear_q_r    <= bus.clear_req;
      clear_done_r <= 1'b0;
      case (state_r)
        ARB: begin
          cnt_r <= '0;
          if (clear_rise_s) begin
            state_r      <= CLEAR;
            clear_busy_r <= 1'b1;
          end else begin
            state_r      <= ARB;
            clear_busy_r <= 1'b0;
          end
        end
        CLEAR: begin
          if (last_s) begin
            state_r      <= ARB;
            cnt_r        <= '0;
            clear_busy_r <= 1'b0;
            clear_done_r <= 1'b1;
          end else begin
            state_r      <= CLEAR;
            cnt_r        <= issue_s + CNT_W'(1);
            clear_busy_r <= 1'b1;
          end
        end
        default: begin
          state_r      <= ARB;
          cnt_r        <= '0;
          clear_busy_r <= 1'b0;
        end
      endcase
    end
  end

  // Registered BRAM port: the winner of cycle N drives the BRAM in cycle N+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      bram_en_r   <= 1'b0;
      bram_we_r   <= 1'b0;
      bram_addr_r <= '0;
      bram_din_r  <= '0;
    end else begin
      case (sel_s)
        SEL_CLR: begin
          bram_en_r   <= 1'b1;
          bram_we_r   <= 1'b1;
          bram_addr_r <= issue_s[ADDR_W-1:0];
          bram_din_r  <= '0;
        end
        SEL_ACC: begin
          bram_en_r   <= 1'b1;
          bram_we_r   <= 1'b1;
          bram_addr_r <= bus.acc_addr;
          bram_din_r  <= bus.acc_wdata;
        end
        SEL_RD: begin
          bram_en_r   <= 1'b1;
          bram_we_r   <= 1'b0;
          bram_addr_r <= bus.rd_addr;
          bram_din_r  <= '0;
        end
        default: begin
          bram_en_r   <= 1'b0;
          bram_we_r   <= 1'b0;
          bram_addr_r <= '0;
          bram_din_r  <= '0;
        end
      endcase
    end
  end

  // Read-valid pipeline tracking the port register plus BRAM latency; only reset flushes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v1_r    <= 1'b0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_v1_r    <= (sel_s == SEL_RD);
      rd_valid_r <= rd_v1_r;
    end
  end

  assign bus.acc_gnt    = acc_win_s;
  assign bus.rd_gnt     = rd_win_s;
  assign bus.clear_busy = clear_busy_r;
  assign bus.clear_done = clear_done_r;
  assign bus.rd_valid   = rd_valid_r;
  assign bus.rd_data    = rd_valid_r ? bus.bram_dout : '0;
  assign bus.bram_en    = bram_en_r;
  assign bus.bram_we    = bram_we_r;
  assign bus.bram_addr  = bram_addr_r;
  assign bus.bram_din   = bram_din_r;

endmodule

// File: doc/obuf_port_arbiter.md
# obuf_port_arbiter

Sequencer and arbiter for the single write/read port of the transpose-convolution output BRAM. It shares that port among three requesters: a zero-fill clear sweep triggered by the layer-transition clear pulse, the accumulator write-back path, and the PS readout path. It sits between the Auto_Scheduler outputs, the accumulator datapath and the output BRAM primitive.

## Interface
Parameters:
- `ADDR_W`, 10, output BRAM address width.
- `DATA_W`, 16, output BRAM data width.
- `DEPTH`, 1024, number of words swept by a clear; must satisfy `DEPTH <= 2**ADDR_W`.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clear_req`  in  1  one-cycle (or multi-cycle) request to zero-fill the BRAM; wired to `clear_output_bram`.
- `clear_busy`  out  1  sweep in progress.
- `clear_done`  out  1  one-cycle pulse when the sweep finishes.
- `acc_req`  in  1  accumulator write request.
- `acc_addr`  in  ADDR_W  accumulator write address.
- `acc_wdata`  in  DATA_W  accumulator write data.
- `acc_gnt`  out  1  accumulator write accepted this cycle.
- `rd_req`  in  1  readout request.
- `rd_addr`  in  ADDR_W  readout address.
- `rd_gnt`  out  1  readout accepted this cycle.
- `rd_valid`  out  1  `rd_data` valid.
- `rd_data`  out  DATA_W  read data.
- `bram_en`  out  1  BRAM port enable.
- `bram_we`  out  1  BRAM port write enable.
- `bram_addr`  out  ADDR_W  BRAM port address.
- `bram_din`  out  DATA_W  BRAM port write data.
- `bram_dout`  in  DATA_W  BRAM port read data; 1-cycle read latency.

## Operation
State machine states:
- `ARB`: normal arbitration. A rising `clear_req` goes to `CLEAR`, with the sweep counter set to 0.
- `CLEAR`:
  - Issues one write of 0 per cycle at counter addresses 0 to `DEPTH-1`.
  - `acc_gnt` and `rd_gnt` are held at 0 throughout; requesters stall.
  - After address `DEPTH-1` is issued, returns to `ARB` and pulses `clear_done`.
  - A `clear_req` seen while in `CLEAR` restarts the counter at 0. There is still only one `clear_done`, at the end of the final sweep.

Arbitration in `ARB`:
- Grants are combinational from the request lines. `req && gnt` in the same cycle is a transfer.
- At most one grant per cycle.
- Only `acc_req` → `acc_gnt`; only `rd_req` → `rd_gnt`.
- Both requesting: winner chosen as described under Configuration.
- `clear_req` takes precedence over both. In the cycle `clear_req` is sampled high in `ARB`, both grants are 0.

Counter and arithmetic rules:
- Counter width is `ADDR_W+1` so that `DEPTH = 2**ADDR_W` does not wrap early.
- `bram_addr` takes the low `ADDR_W` bits of the counter.

In-flight reads:
- Reads granted before a clear still return their data.
- The `rd_valid` pipeline is never flushed, except by `rst`.

## Timing
- All outputs are 0 after reset; the state machine is in `ARB` and the `rd_valid` pipeline is empty.
- BRAM port signals (`bram_en`, `bram_we`, `bram_addr`, `bram_din`) are registered. A transfer in cycle N appears at the BRAM in cycle N+1.
- Read latency: a handshake in cycle N gives `rd_valid=1` and `rd_data` in cycle N+2. Back-to-back grants give back-to-back `rd_valid`.
- Clear sequence:
  - `clear_req` in cycle N.
  - `clear_busy=1` from N+1 to N+DEPTH.
  - Zero writes reach the BRAM in cycles N+2 to N+DEPTH+1.
  - `clear_done` pulses in cycle N+DEPTH+1.
  - Grants resume in N+DEPTH+1.
- Synchronous `rst` mid-sweep aborts the sweep. `clear_done` is not pulsed and the BRAM contents are left partially cleared.

## Configuration
`OBUF_ARB_RR_EN`:
- Defined: round-robin between `acc` and `rd`. A 1-bit last-winner register gives priority to the requester that lost the most recent contested cycle. It resets so that `acc` wins first, and it updates only on contested cycles.
- Undefined: fixed priority, `acc` over `rd`. `rd` can starve while `acc_req` is held high.

## Structure
- Package `obuf_arb_pkg`:
  - State enum (`ARB`, `CLEAR`).
  - Grant-select encoding (`SEL_NONE`, `SEL_ACC`, `SEL_RD`, `SEL_CLR`).
  - Default `ADDR_W`, `DATA_W` and `DEPTH` constants.
- Sub-module `obuf_rr_arb2`:
  - 2-requester arbiter with the last-winner register.
  - Instantiated only under `OBUF_ARB_RR_EN`; the fixed-priority path is inline logic.

## Test plan
- Reset, then idle: all outputs 0. `acc_req=1`, `acc_addr=5`, `acc_wdata=0x1234` → `acc_gnt=1` that cycle; BRAM sees `we=1`, `addr=5`, `din=0x1234` one cycle later.
- Read at address 5 after that write → `rd_gnt=1`, then `rd_valid=1` with `rd_data=0x1234` exactly 2 cycles later.
- `clear_req` pulse with `DEPTH=16` → `clear_busy` for 16 cycles, 16 zero writes to addresses 0..15, `clear_done` at N+17. `acc_req` held throughout sees `acc_gnt=0` until N+17. A subsequent read of address 5 returns 0.
- Second `clear_req` at sweep address 7 → counter restarts at 0, and there is a single `clear_done`, 16 cycles after the second request.
- `acc_req` and `rd_req` held high together for 6 cycles:
  - With `OBUF_ARB_RR_EN`: grants alternate acc, rd, acc, rd, acc, rd.
  - Without it: all 6 grants go to acc.
- `rst` asserted at sweep address 3 → next cycle `clear_busy=0`, no `clear_done`, state `ARB`, and an in-flight `rd_valid` is dropped.
